// File: rtl/alu_1bit.sv
// ---------------------------------------------------------------------------
// alu_1bit
//
// Single-bit slice of a ripple-carry, MIPS-style N-bit ALU. Supports AND, OR,
// ADD, SUB, NAND, NOR and SLT through the external Ainvert/Binvert/c_in
// controls. The carry and sum outputs are combinational so that slices can be
// chained and the SLT feedback path stays unregistered. The function result
// and the signed-overflow flag are registered on clk.
//
// Ports:
//   clk      in   system clock, registers update on the rising edge
//   rst      in   asynchronous, active-high reset of the output registers
//   en       in   capture enable for the output registers
//   a, b     in   operand bits
//   less     in   SLT input (set of the MSB slice for bit 0, else 0)
//   Ainvert  in   invert a before the function unit
//   Binvert  in   invert b before the function unit
//   c_in     in   carry in from the previous slice (Binvert at bit 0)
//   op[1:0]  in   00 AND, 01 OR, 10 ADD, 11 LESS
//   result   out  registered function result
//   c_out    out  combinational carry out to the next slice
//   set      out  combinational adder sum bit (SLT source in the MSB slice)
//   overflow out  registered signed-overflow flag (MSB slice only)
//
// Build option:
//   ALU_1BIT_OVF_EN  when defined, the overflow XOR and its flop are built;
//                    otherwise overflow is tied to 0 (use in non-MSB slices).
// ---------------------------------------------------------------------------
module alu_1bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       a,
   input  logic       b,
   input  logic       less,
   input  logic       Ainvert,
   input  logic       Binvert,
   input  logic       c_in,
   input  logic [1:0] op,
   output logic       result,
   output logic       c_out,
   output logic       set,
   output logic       overflow
);

   logic aa;
   logic bb;
   logic sum;
   logic result_d;
   logic result_q;

   // Operand conditioning: the word-level control decides whether each
   // operand is used true or complemented (SUB/SLT invert b, NAND/NOR
   // invert both and rely on De Morgan).
   assign aa = a ^ Ainvert;
   assign bb = b ^ Binvert;

   // Full adder on the conditioned operands. Kept combinational so the
   // carry can ripple through the whole word within one cycle.
   assign sum   = aa ^ bb ^ c_in;
   assign c_out = (aa & bb) | (aa & c_in) | (bb & c_in);

   // The sum leaves the slice regardless of op; in the MSB slice it is the
   // sign of a-b and feeds the less input of bit 0 for SLT.
   assign set = sum;

   // Function select. Any op value that is not a clean binary code falls
   // into the default and yields 0 rather than propagating an unknown.
   always_comb begin
      result_d = 1'b0;
      case (op)
         2'b00:   result_d = aa & bb;
         2'b01:   result_d = aa | bb;
         2'b10:   result_d = sum;
         2'b11:   result_d = less;
         default: result_d = 1'b0;
      endcase
   end

   // Result register: cleared asynchronously by rst, otherwise captures the
   // selected function on enabled edges and holds when en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= 1'b0;
      end else if (en) begin
         result_q <= result_d;
      end
   end

   assign result = result_q;

`ifdef ALU_1BIT_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Signed overflow is the disagreement between the carry into and out of
   // the sign bit. It is evaluated independently of op and is only
   // meaningful when this slice is the MSB.
   assign ovf_d = c_in ^ c_out;

   // Overflow register shares the reset and enable behaviour of result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`else
   // Non-MSB slices have no use for an overflow flag.
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_1bit.sv
// ---------------------------------------------------------------------------
// tb_alu_1bit
//
// Self-checking bench for alu_1bit. A behavioural model computes the
// expected outputs from operand arithmetic; a compare process checks the
// DUT against it every falling edge, and directed tests pin the model with
// hand-computed literal values before a randomized run.
// Honours ALU_1BIT_OVF_EN for the expected overflow behaviour.
// ---------------------------------------------------------------------------
module tb_alu_1bit;

   logic       clk;
   logic       rst;
   logic       en;
   logic       a;
   logic       b;
   logic       less;
   logic       Ainvert;
   logic       Binvert;
   logic       c_in;
   logic [1:0] op;
   logic       result;
   logic       c_out;
   logic       set;
   logic       overflow;

   int tests_run;
   int tests_failed;
   bit compare_on;

   logic model_result;
   logic model_ovf;

   alu_1bit dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .a        (a),
      .b        (b),
      .less     (less),
      .Ainvert  (Ainvert),
      .Binvert  (Binvert),
      .c_in     (c_in),
      .op       (op),
      .result   (result),
      .c_out    (c_out),
      .set      (set),
      .overflow (overflow)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Arithmetic view of one column of the adder: the conditioned operands
   // plus carry-in counted as integers.
   function automatic int column_total(input logic fa, input logic fb,
                                       input logic fai, input logic fbi,
                                       input logic fc);
      int va;
      int vb;
      va = fai ? 1 - int'(fa) : int'(fa);
      vb = fbi ? 1 - int'(fb) : int'(fb);
      return va + vb + int'(fc);
   endfunction

   function automatic logic model_sum(input logic fa, input logic fb,
                                      input logic fai, input logic fbi,
                                      input logic fc);
      return logic'(column_total(fa, fb, fai, fbi, fc) % 2);
   endfunction

   function automatic logic model_carry(input logic fa, input logic fb,
                                        input logic fai, input logic fbi,
                                        input logic fc);
      return logic'(column_total(fa, fb, fai, fbi, fc) / 2);
   endfunction

   // Expected function output for one set of inputs.
   function automatic logic model_func(input logic fa, input logic fb,
                                       input logic fl, input logic fai,
                                       input logic fbi, input logic fc,
                                       input logic [1:0] fop);
      int va;
      int vb;
      va = fai ? 1 - int'(fa) : int'(fa);
      vb = fbi ? 1 - int'(fb) : int'(fb);
      if (^fop === 1'bx) return 1'b0;
      case (fop)
         2'd0:    return logic'(va * vb);
         2'd1:    return logic'((va + vb) > 0);
         2'd2:    return model_sum(fa, fb, fai, fbi, fc);
         2'd3:    return fl;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic model_overflow(input logic fa, input logic fb,
                                           input logic fai, input logic fbi,
                                           input logic fc);
`ifdef ALU_1BIT_OVF_EN
      return logic'(fc != model_carry(fa, fb, fai, fbi, fc));
`else
      return 1'b0;
`endif
   endfunction

   // Registered part of the model: what the outputs must show after each
   // enabled edge, and zero whenever reset is asserted.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_result = 1'b0;
         model_ovf    = 1'b0;
      end else if (en) begin
         model_result = model_func(a, b, less, Ainvert, Binvert, c_in, op);
         model_ovf    = model_overflow(a, b, Ainvert, Binvert, c_in);
      end
   end

   task automatic checkOutput(input string name, input logic actual,
                              input logic expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Compare process: every falling edge, registered outputs against the
   // model state and combinational outputs against the current inputs.
   always @(negedge clk) begin
      if (compare_on) begin
         checkOutput("cmp_result", result, model_result);
         checkOutput("cmp_overflow", overflow, model_ovf);
         checkOutput("cmp_set", set,
                     model_sum(a, b, Ainvert, Binvert, c_in));
         checkOutput("cmp_c_out", c_out,
                     model_carry(a, b, Ainvert, Binvert, c_in));
      end
   end

   // Drive a full input vector shortly after a falling edge.
   task automatic applyStimulus(input logic ia, input logic ib,
                                input logic il, input logic iai,
                                input logic ibi, input logic ic,
                                input logic [1:0] iop, input logic ien);
      @(negedge clk);
      #1;
      a       = ia;
      b       = ib;
      less    = il;
      Ainvert = iai;
      Binvert = ibi;
      c_in    = ic;
      op      = iop;
      en      = ien;
   endtask

   task automatic afterEdge();
      @(posedge clk);
      #1;
   endtask

   logic exp_ovf_hi;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      compare_on   = 1'b0;
      rst = 1'b1;
      en = 1'b0; a = 1'b0; b = 1'b0; less = 1'b0;
      Ainvert = 1'b0; Binvert = 1'b0; c_in = 1'b0; op = 2'b00;
`ifdef ALU_1BIT_OVF_EN
      exp_ovf_hi = 1'b1;
`else
      exp_ovf_hi = 1'b0;
`endif
      #12;
      checkOutput("reset_result", result, 1'b0);
      checkOutput("reset_overflow", overflow, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      compare_on = 1'b1;

      // Reset while holding a captured 1: clears immediately and stays
      // cleared across an enabled edge.
      applyStimulus(1, 0, 0, 0, 0, 0, 2'b01, 1);
      afterEdge();
      checkOutput("pre_reset_result", result, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_result", result, 1'b0);
      checkOutput("async_reset_overflow", overflow, 1'b0);
      afterEdge();
      checkOutput("reset_hold_result", result, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b0;

      // ADD sweep over every {a,b,c_in}.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(logic'(i >> 2), logic'(i >> 1), 0, 0, 0,
                       logic'(i), 2'b10, 1);
         afterEdge();
      end
      applyStimulus(1, 1, 0, 0, 0, 0, 2'b10, 1);
      #1;
      checkOutput("add110_set", set, 1'b0);
      checkOutput("add110_c_out", c_out, 1'b1);
      afterEdge();
      checkOutput("add110_result", result, 1'b0);
      checkOutput("add110_overflow", overflow, exp_ovf_hi);
      applyStimulus(1, 1, 0, 0, 0, 1, 2'b10, 1);
      afterEdge();
      checkOutput("add111_result", result, 1'b1);
      checkOutput("add111_overflow", overflow, 1'b0);

      // Logic operations with a=1, b=0.
      applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 1);
      afterEdge();
      checkOutput("and_result", result, 1'b0);
      applyStimulus(1, 0, 0, 0, 0, 0, 2'b01, 1);
      afterEdge();
      checkOutput("or_result", result, 1'b1);
      applyStimulus(1, 0, 0, 1, 1, 0, 2'b01, 1);
      afterEdge();
      checkOutput("nand_result", result, 1'b1);
      applyStimulus(1, 0, 0, 1, 1, 0, 2'b00, 1);
      afterEdge();
      checkOutput("nor_result", result, 1'b0);

      // SUB/SLT column with b inverted and carry-in 1: 0 + 0 + 1.
      applyStimulus(0, 1, 1, 0, 1, 1, 2'b11, 1);
      #1;
      checkOutput("sub_set", set, 1'b1);
      checkOutput("sub_c_out", c_out, 1'b0);
      afterEdge();
      checkOutput("slt_less1_result", result, 1'b1);
      applyStimulus(0, 1, 0, 0, 1, 1, 2'b11, 1);
      afterEdge();
      checkOutput("slt_less0_result", result, 1'b0);

      // Hold: capture a 1, then change inputs with en low.
      applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 1);
      afterEdge();
      checkOutput("hold_capture", result, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
      afterEdge();
      checkOutput("hold_result_1", result, 1'b1);
      applyStimulus(0, 1, 0, 1, 0, 1, 2'b10, 0);
      afterEdge();
      checkOutput("hold_result_2", result, 1'b1);

      // Unknown op with en high gives 0.
      applyStimulus(0, 0, 0, 0, 0, 0, 2'bxx, 1);
      afterEdge();
      checkOutput("unknown_op_result", result, 1'b0);

      // Randomized run with occasional reset pulses and enable gaps.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(logic'($urandom_range(1)), logic'($urandom_range(1)),
                       logic'($urandom_range(1)), logic'($urandom_range(1)),
                       logic'($urandom_range(1)), logic'($urandom_range(1)),
                       2'($urandom_range(3)), logic'($urandom_range(3) != 0));
         rst = ($urandom_range(31) == 0);
      end
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      compare_on = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
